// File: rtl/serial_compare_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_compare_if : operand / handshake bundle, GCD controller <-> cmp   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface serial_compare_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;
  logic             neq;

  modport master (
    output start, signed_mode, d1, d2,
    input  busy, done, lt, eq, gt, neq
  );

  modport slave (
    input  start, signed_mode, d1, d2,
    output busy, done, lt, eq, gt, neq
  );
endinterface
`default_nettype wire

// File: rtl/serial_compare.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_compare : MSB-first digit-serial magnitude compare, signed/uns.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module serial_compare #(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  serial_compare_if.slave bus
);
  localparam int NDIG  = WIDTH / DIGIT;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NDIG - 1);
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dec_q, dec_d;
  logic             dlt_q, dlt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;

  // Operands shift left each compare cycle, so the live digit is always on top.
  logic [DIGIT-1:0] digit_a;
  logic [DIGIT-1:0] digit_b;
  logic             digit_ne;
  logic             digit_lt;

  assign digit_a  = a_q[WIDTH-1 -: DIGIT];
  assign digit_b  = b_q[WIDTH-1 -: DIGIT];
  assign digit_ne = (digit_a != digit_b);
  assign digit_lt = (digit_a < digit_b);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    dlt_d   = dlt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Biasing the sign bit turns a two's-complement compare into an unsigned one.
          a_d     = bus.d1 ^ (bus.signed_mode ? SIGN_MASK : '0);
          b_d     = bus.d2 ^ (bus.signed_mode ? SIGN_MASK : '0);
          idx_d   = '0;
          dec_d   = 1'b0;
          dlt_d   = 1'b0;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        a_d   = a_q << DIGIT;
        b_d   = b_q << DIGIT;
        idx_d = idx_q + IDX_W'(1);
        if (!dec_q && digit_ne) begin
          dec_d = 1'b1;
          dlt_d = digit_lt;
        end
        if (idx_q == LAST_IDX || (EARLY_EXIT != 0 && digit_ne)) begin
          state_d = S_DONE;
          lt_d    = dec_q ? dlt_q  : digit_lt;
          gt_d    = dec_q ? ~dlt_q : (digit_ne & ~digit_lt);
          eq_d    = ~dec_q & ~digit_ne;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      dec_q   <= 1'b0;
      dlt_q   <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      dlt_q   <= dlt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.lt   = lt_q;
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;
  assign bus.neq  = lt_q | gt_q;

endmodule
`default_nettype wire
